// File: rtl/fixed_to_float_seq.sv
// rtl/fixed_to_float_seq.sv - sequential fixed-point to IEEE-754 single converter
// One word in flight: capture, normalise one shift per cycle, round to nearest-even, pack.
module fixed_to_float_seq #(
   parameter int WIDTH     = 22,
   parameter int FRAC_BITS = 21,
   parameter int SIGNED    = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_data
);

   // Exponent is kept wider than 8 bits so the intermediate arithmetic never wraps.
   localparam int EW = 10;
   localparam logic [EW-1:0] EXP_INIT = EW'(127 + WIDTH - 1 - FRAC_BITS);
   // Fraction is left-aligned into at least 25 bits: 23 kept, guard, one sticky position.
   localparam int EXT   = (WIDTH - 1 > 25) ? WIDTH - 1 : 25;
   localparam int AL_SH = EXT - (WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_NORM,
      S_ROUND,
      S_DONE
   } state_t;

   state_t           r_state;
   logic             r_sign;
   logic [WIDTH-1:0] r_mag;
   logic [EW-1:0]    r_exp;
   logic             r_in_ready;
   logic             r_out_valid;
   logic [31:0]      r_out_data;

   logic             w_sign_in;
   logic [WIDTH-1:0] w_mag_in;
   logic [EXT-1:0]   w_frac_lo;
   logic [EXT-1:0]   w_frac_al;
   logic [22:0]      w_mant_t;
   logic             w_guard;
   logic             w_sticky;
   logic             w_rnd_up;
   logic [23:0]      w_mant_sum;
   logic [EW-1:0]    w_exp_fin;
   logic             w_unused;

   // Sign and magnitude of the incoming word; the most-negative value maps to 2^(WIDTH-1).
   assign w_sign_in = (SIGNED != 0) && in_data[WIDTH-1];
   assign w_mag_in  = w_sign_in ? -in_data : in_data;

   // Round-to-nearest-even on the normalised magnitude; implicit leading one is dropped.
   always_comb begin
      w_frac_lo  = EXT'(r_mag[WIDTH-2:0]);
      w_frac_al  = w_frac_lo << AL_SH;
      w_mant_t   = w_frac_al[EXT-1 -: 23];
      w_guard    = w_frac_al[EXT-24];
      w_sticky   = |w_frac_al[EXT-25:0];
      w_rnd_up   = w_guard & (w_sticky | w_mant_t[0]);
      w_mant_sum = {1'b0, w_mant_t} + {23'b0, w_rnd_up};
      // A carry out of the mantissa leaves it all-zero and bumps the exponent.
      w_exp_fin  = r_exp + (w_mant_sum[23] ? EW'(1) : EW'(0));
   end

   // Upper exponent bits only guard against wrap; they never reach the packed result.
   assign w_unused = ^w_exp_fin[EW-1:8];

   // Control FSM with registered handshake outputs and result.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_sign      <= 1'b0;
         r_mag       <= '0;
         r_exp       <= '0;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  r_sign     <= w_sign_in;
                  r_mag      <= w_mag_in;
                  r_exp      <= EXP_INIT;
                  r_in_ready <= 1'b0;
                  if (w_mag_in == '0) begin
                     // Zero always packs as +0, whatever the input sign.
                     r_out_data  <= '0;
                     r_out_valid <= 1'b1;
                     r_state     <= S_DONE;
                  end else begin
                     r_state <= S_NORM;
                  end
               end
            end
            S_NORM: begin
               if (r_mag[WIDTH-1]) begin
                  r_state <= S_ROUND;
               end else begin
                  r_mag <= r_mag << 1;
                  r_exp <= r_exp - EW'(1);
               end
            end
            S_ROUND: begin
               r_out_data  <= {r_sign, w_exp_fin[7:0], w_mant_sum[22:0]};
               r_out_valid <= 1'b1;
               r_state     <= S_DONE;
            end
            S_DONE: begin
               if (out_ready) begin
                  r_out_valid <= 1'b0;
                  r_in_ready  <= 1'b1;
                  r_state     <= S_IDLE;
               end
            end
            default: begin
               r_state     <= S_IDLE;
               r_in_ready  <= 1'b1;
               r_out_valid <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;

endmodule

// File: tb/tb_fixed_to_float_seq.sv
// tb/tb_fixed_to_float_seq.sv - directed bench for fixed_to_float_seq in three configurations
module tb_fixed_to_float_seq;

   logic        clk;
   logic        rst_n;
   logic        drv_valid;
   logic [31:0] drv_data;
   logic        drv_oready;
   int          cur_sel;

   int n_total;
   int n_bad;

   logic        in_valid_a, in_ready_a, out_valid_a;
   logic [21:0] in_data_a;
   logic [31:0] out_data_a;
   logic        in_valid_b, in_ready_b, out_valid_b;
   logic [21:0] in_data_b;
   logic [31:0] out_data_b;
   logic        in_valid_c, in_ready_c, out_valid_c;
   logic [31:0] in_data_c;
   logic [31:0] out_data_c;

   logic        m_ready;
   logic        m_valid;
   logic [31:0] m_data;

   fixed_to_float_seq #(.WIDTH(22), .FRAC_BITS(21), .SIGNED(0)) u_dut_a (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid_a), .in_ready(in_ready_a), .in_data(in_data_a),
      .out_valid(out_valid_a), .out_ready(drv_oready), .out_data(out_data_a)
   );

   fixed_to_float_seq #(.WIDTH(22), .FRAC_BITS(21), .SIGNED(1)) u_dut_b (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid_b), .in_ready(in_ready_b), .in_data(in_data_b),
      .out_valid(out_valid_b), .out_ready(drv_oready), .out_data(out_data_b)
   );

   fixed_to_float_seq #(.WIDTH(32), .FRAC_BITS(0), .SIGNED(0)) u_dut_c (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid_c), .in_ready(in_ready_c), .in_data(in_data_c),
      .out_valid(out_valid_c), .out_ready(drv_oready), .out_data(out_data_c)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign in_valid_a = drv_valid && (cur_sel == 0);
   assign in_valid_b = drv_valid && (cur_sel == 1);
   assign in_valid_c = drv_valid && (cur_sel == 2);
   assign in_data_a  = drv_data[21:0];
   assign in_data_b  = drv_data[21:0];
   assign in_data_c  = drv_data;

   always_comb begin
      m_ready = in_ready_a;
      m_valid = out_valid_a;
      m_data  = out_data_a;
      if (cur_sel == 1) begin
         m_ready = in_ready_b;
         m_valid = out_valid_b;
         m_data  = out_data_b;
      end else if (cur_sel == 2) begin
         m_ready = in_ready_c;
         m_valid = out_valid_c;
         m_data  = out_data_c;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic do_xfer(input int sel, input logic [31:0] din, input logic [31:0] exp_out,
                          input int exp_lat, input string tag);
      int lat;
      int wait_cnt;
      cur_sel  = sel;
      wait_cnt = 0;
      while (!m_ready && wait_cnt < 100) begin
         @(posedge clk); #1;
         wait_cnt++;
      end
      check({tag, "_rdy"}, {31'b0, m_ready}, 32'd1);
      drv_data  = din;
      drv_valid = 1'b1;
      @(posedge clk); #1;
      drv_valid = 1'b0;
      lat = 1;
      check({tag, "_busy"}, {31'b0, m_ready}, 32'd0);
      while (!m_valid && lat < 200) begin
         @(posedge clk); #1;
         lat++;
      end
      check({tag, "_data"}, m_data, exp_out);
      check({tag, "_lat"}, lat, exp_lat);
      if (drv_oready) begin
         @(posedge clk); #1;
         check({tag, "_ov_clr"}, {31'b0, m_valid}, 32'd0);
         check({tag, "_ir_set"}, {31'b0, m_ready}, 32'd1);
      end
   endtask

   initial begin
      int stable;
      n_total    = 0;
      n_bad      = 0;
      cur_sel    = 0;
      drv_valid  = 1'b0;
      drv_data   = '0;
      drv_oready = 1'b1;
      rst_n      = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_ready", {31'b0, m_ready}, 32'd1);
      check("rst_valid", {31'b0, m_valid}, 32'd0);
      check("rst_data", m_data, 32'h0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Unsigned default configuration
      do_xfer(0, 32'h200000, 32'h3F800000, 3,  "u_one");
      do_xfer(0, 32'h114BC6, 32'h3F0A5E30, 4,  "u_0p54");
      do_xfer(0, 32'h1FAE14, 32'h3F7D70A0, 4,  "u_0p99");
      do_xfer(0, 32'h000000, 32'h00000000, 1,  "u_zero");
      do_xfer(0, 32'h000001, 32'h35000000, 24, "u_lsb");

      // Two's-complement configuration
      do_xfer(1, 32'h200000, 32'hBF800000, 3,  "s_m1");
      do_xfer(1, 32'h3FFFFF, 32'hB5000000, 24, "s_mlsb");
      do_xfer(1, 32'h000000, 32'h00000000, 1,  "s_zero");

      // Wide integer configuration exercising rounding
      do_xfer(2, 32'h01000001, 32'h4B800000, 10, "r_tie_dn");
      do_xfer(2, 32'h01000003, 32'h4B800002, 10, "r_tie_up");
      do_xfer(2, 32'h01FFFFFF, 32'h4C000000, 10, "r_carry");

      // Backpressure: result must hold and a new word must not be taken
      drv_oready = 1'b0;
      do_xfer(0, 32'h200000, 32'h3F800000, 3, "bp");
      stable    = 0;
      drv_data  = 32'h114BC6;
      drv_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         if (m_valid && m_data == 32'h3F800000 && !m_ready) stable++;
      end
      check("bp_hold", stable, 10);
      drv_valid  = 1'b0;
      drv_oready = 1'b1;
      @(posedge clk); #1;
      check("bp_rel_valid", {31'b0, m_valid}, 32'd0);
      check("bp_rel_ready", {31'b0, m_ready}, 32'd1);
      @(posedge clk); #1;
      check("bp_no_accept", {31'b0, m_ready}, 32'd1);

      // Reset while normalising
      cur_sel   = 0;
      drv_data  = 32'h000001;
      drv_valid = 1'b1;
      @(posedge clk); #1;
      drv_valid = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      check("mid_busy", {31'b0, m_ready}, 32'd0);
      rst_n = 1'b0;
      @(posedge clk); #1;
      check("mid_rst_ready", {31'b0, m_ready}, 32'd1);
      check("mid_rst_valid", {31'b0, m_valid}, 32'd0);
      check("mid_rst_data", m_data, 32'h0);
      rst_n = 1'b1;
      do_xfer(0, 32'h200000, 32'h3F800000, 3, "after_rst");

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

// File: doc/fixed_to_float_seq.md
Name: fixed_to_float_seq

Overview:
- Parametrised, sequential successor to the combinational fixed_to_float packer.
- Accepts one fixed-point word (unsigned or two's-complement, configurable width and binary point) over a valid/ready handshake.
- Normalises it iteratively, one shift per cycle, then rounds to nearest-even and packs an IEEE-754 single.
- Sits between CORDIC output stages and any float-consuming sink; provides backpressure in both directions.

Parameters:
- WIDTH, 22: input word width; legal range 2..64.
- FRAC_BITS, 21: fractional bits of the input; legal range 0..WIDTH-1.
- SIGNED, 0: 0 = unsigned input; 1 = two's-complement input.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous reset, active-low.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  block can accept a word.
- in_data  in  WIDTH  fixed-point operand.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  sink accepts out_data.
- out_data  out  32  IEEE-754 single result.

Behaviour:
- Reset (rst_n low at a clk edge): state=IDLE, in_ready=1, out_valid=0, out_data=0, internal regs=0. Reset takes priority over any state or transfer; a word in flight is discarded.
- Handshake: a transfer occurs on a clk edge when valid&&ready. in_ready=1 only in IDLE. out_valid=1 only in DONE. Non-blocking: one word in flight at a time.
- IDLE:
  - On input accept, capture sign = SIGNED & in_data[WIDTH-1].
  - mag = sign ? -in_data : in_data, as a WIDTH-bit unsigned value. The most-negative input yields 2^(WIDTH-1) correctly.
  - exp = 127 + (WIDTH-1-FRAC_BITS), signed, 9 bits minimum.
  - If mag==0: out_data = {sign=0, 31'b0} (always +0), go to DONE. Otherwise go to NORM.
- NORM, evaluated each cycle:
  - If mag[WIDTH-1]==1, go to ROUND.
  - Else mag <<= 1, exp -= 1, stay in NORM.
- ROUND:
  - Fraction field = mag[WIDTH-2:0], left-aligned into 23 bits.
  - If WIDTH-1 <= 23: zero-pad, no rounding.
  - Else: guard = next bit below the 23 kept bits; sticky = OR of all remaining lower bits. Increment the mantissa if guard && (sticky || mantissa LSB).
  - Mantissa carry-out: mantissa=0, exp+=1.
  - out_data = {sign, exp[7:0], mantissa}; go to DONE.
- DONE: out_data held stable while out_valid && !out_ready. On out_ready, go to IDLE, out_valid=0. The next input can be accepted one cycle later.
- Latency, from the accept edge to the edge after which out_valid=1:
  - Non-zero input: 3+s cycles, where s = leading-zero count of mag (0..WIDTH-1).
  - Zero input: 1 cycle.
- Exponent range: for legal parameters, exp stays within 1..254, so no denormal, overflow or inf/NaN path is needed.
- in_valid while not in IDLE is ignored; the source must hold its word until in_ready.

Test Plan:
- Defaults, in_data=22'h200000 (1.0), out_ready=1 -> out_data=32'h3F800000, out_valid 3 cycles after accept, in_ready low throughout.
- Defaults, in_data=22'h114BC6 (~0.5405) -> 32'h3F0A5E30 after 4 cycles. Then in_data=22'h1FAE14 (~0.99) -> 32'h3F7D70A0 after 4 cycles. Then in_data=0 -> 32'h00000000 after 1 cycle.
- SIGNED=1, WIDTH=22, FRAC_BITS=21:
  - in_data=22'h200000 (-1.0) -> 32'hBF800000.
  - in_data=22'h3FFFFF (-2^-21) -> 32'hB5000000 after 24 cycles.
- WIDTH=32, FRAC_BITS=0, unsigned (rounding):
  - 32'h01000001 -> 32'h4B800000 (tie to even, down).
  - 32'h01000003 -> 32'h4B800002 (tie to even, up).
  - 32'h01FFFFFF -> 32'h4C000000 (mantissa carry bumps exponent).
- Backpressure: hold out_ready=0 for 10 cycles after out_valid -> out_data and out_valid stable, in_ready=0, a new in_valid is not accepted. Release out_ready -> one transfer, in_ready=1 on the next cycle.
- Reset mid-operation: accept 22'h000001 (21 shifts), assert rst_n=0 during NORM -> next edge gives state=IDLE, out_valid=0, out_data=0, in_ready=1. The next accepted 22'h200000 produces 32'h3F800000 normally.
